// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use, branch-flush and multi-cycle RV32M stall control for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters; otherwise those ports read zero.
module hazard_stall_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [6:0]  ex_opcode,
    input  logic [6:0]  ex_func7,
    input  logic [2:0]  ex_func3,
    input  logic        ex_wb_load,
    input  logic [4:0]  ex_wb_rd,
    input  logic        ex_branch_taken,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
);
    localparam int MAX_LAT = DIV_CYCLES > MUL_CYCLES ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW = MAX_LAT > 0 ? $clog2(MAX_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          m_op, lat_zero, mdu_stall, load_use;
    int            lat;

    assign m_op     = ex_opcode == 7'b0110011 && ex_func7 == 7'b0000001;
    assign lat      = ex_func3[2] ? DIV_CYCLES : MUL_CYCLES;
    assign lat_zero = lat == 0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: if (m_op && !lat_zero) begin
                state_nx = WAIT;
                cnt_nx   = CW'(lat - 1);
            end
            WAIT: if (cnt == '0) state_nx = DONE;
                  else cnt_nx = cnt - 1'b1;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stall is Mealy in IDLE so the pipeline freezes the same cycle the M-op lands in EX
    assign mdu_stall = (state == IDLE && m_op && !lat_zero) || state == WAIT;
    assign load_use  = ex_wb_load && ex_wb_rd != 5'd0 &&
                       ((id_uses_rs1 && id_rs1 == ex_wb_rd) || (id_uses_rs2 && id_rs2 == ex_wb_rd));

    assign pc_hold       = !ex_branch_taken && (mdu_stall || load_use);
    assign if_id_hold    = pc_hold;
    assign if_id_flush   = ex_branch_taken;
    assign id_ex_hold    = !ex_branch_taken && mdu_stall;
    assign id_ex_bubble  = ex_branch_taken || (!mdu_stall && load_use);
    assign ex_mem_bubble = id_ex_hold;
    assign mdu_busy      = state == WAIT;
    assign mdu_done      = state == DONE || (state == IDLE && m_op && lat_zero);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + 32'(pc_hold);
            flush_q <= flush_q + 32'(if_id_flush);
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flushes      = flush_q;
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_flushes      = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: vector table, hand sequences for DIV latency and reset-in-WAIT, and random traffic
// checked against an age-based model of how long each M-op has sat in EX.
module tb_hazard_stall_unit;
    localparam int DIV = 4;
    localparam int MUL = 0;
    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_BR = 7'b1100011, OP_I = 7'b0010011;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  id_rs1, id_rs2, ex_wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_wb_load, ex_branch_taken;
    logic [6:0]  ex_opcode, ex_func7;
    logic [2:0]  ex_func3;
    logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_bubble, mdu_busy, mdu_done;
    logic [31:0] perf_stall_cycles, perf_flushes;
    logic [7:0]  outv;

    int          checks = 0, failures = 0;
    int          age = -1, lat_c = 0, cur_a = -1, cur_l = 0;
    logic [7:0]  exp_o;
    logic [31:0] exp_s = 0, exp_f = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.DIV_CYCLES(DIV), .MUL_CYCLES(MUL)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_opcode(ex_opcode), .ex_func7(ex_func7), .ex_func3(ex_func3),
        .ex_wb_load(ex_wb_load), .ex_wb_rd(ex_wb_rd), .ex_branch_taken(ex_branch_taken),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
    );

    assign outv = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_bubble, mdu_busy, mdu_done};

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t tab[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_opcode = v.opc; ex_func7 = v.f7; ex_func3 = v.f3;
        ex_wb_load = v.ld; ex_wb_rd = v.rd; ex_branch_taken = v.br;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_opcode = OP_I; ex_func7 = 7'd0; ex_func3 = 3'd0;
        ex_wb_load = 1'b0; ex_wb_rd = 5'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_div();
        set_idle();
        ex_opcode = OP_R; ex_func7 = 7'b0000001; ex_func3 = 3'b100;
    endtask

    // age = cycles the current multi-cycle M-op has been in EX; it stalls for ages 0..lat, completes at lat+1
    task automatic model_eval();
        logic m, st, bz, dn, lu;
        int lat, a, l;
        m   = ex_opcode == OP_R && ex_func7 == 7'b0000001;
        lat = ex_func3[2] ? DIV : MUL;
        if (age >= 0) begin a = age; l = lat_c; end
        else begin a = (m && lat > 0) ? 0 : -1; l = lat; end
        st = a >= 0 && a <= l;
        bz = a >= 1 && a <= l;
        dn = (a >= 0 && a == l + 1) || (a < 0 && m && lat == 0);
        lu = ex_wb_load && ex_wb_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_wb_rd) || (id_uses_rs2 && id_rs2 == ex_wb_rd));
        if (ex_branch_taken) exp_o = {6'b001010, bz, dn};
        else if (st)         exp_o = {6'b110101, bz, dn};
        else if (lu)         exp_o = {6'b110010, bz, dn};
        else                 exp_o = {6'b000000, bz, dn};
        cur_a = a;
        cur_l = l;
    endtask

    task automatic model_adv();
        if (cur_a >= 0) begin
            age   = (cur_a == cur_l + 1) ? -1 : cur_a + 1;
            lat_c = cur_l;
        end
        exp_s = exp_s + 32'(exp_o[7]);
        exp_f = exp_f + 32'(exp_o[5]);
    endtask

    task automatic cycle(input string name, input logic use_tab, input logic [7:0] req);
        model_eval();
        @(negedge clk);
        chk(name, 32'(outv), 32'(use_tab ? req : exp_o));
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic gen();
        id_rs1 = 5'($urandom_range(0, 7));
        id_rs2 = 5'($urandom_range(0, 7));
        id_uses_rs1 = 1'($urandom);
        id_uses_rs2 = 1'($urandom);
        ex_wb_rd = 5'($urandom_range(0, 7));
        if (age >= 0) begin
            ex_wb_load = 1'b0;
            ex_branch_taken = 1'b0;
        end else begin
            case ($urandom_range(0, 3))
                0: begin ex_opcode = OP_R; ex_func7 = 7'd1; ex_func3 = 3'($urandom); ex_wb_load = 1'b0; ex_branch_taken = 1'b0; end
                1: begin ex_opcode = OP_LD; ex_func7 = 7'd0; ex_func3 = 3'd2; ex_wb_load = 1'b1; ex_branch_taken = 1'b0; end
                2: begin ex_opcode = OP_BR; ex_func7 = 7'd0; ex_func3 = 3'd0; ex_wb_load = 1'($urandom); ex_branch_taken = 1'b1; end
                default: begin ex_opcode = OP_R; ex_func7 = 7'd0; ex_func3 = 3'($urandom); ex_wb_load = 1'b0; ex_branch_taken = 1'b0; end
            endcase
        end
    endtask

    initial begin
        tab[0]  = '{5'd1, 5'd5, 1'b1, 1'b1, OP_LD, 7'd0, 3'd2, 1'b1, 5'd5, 1'b0, 8'hC8, "lu_rs2"};
        tab[1]  = '{5'd0, 5'd0, 1'b1, 1'b1, OP_LD, 7'd0, 3'd2, 1'b1, 5'd0, 1'b0, 8'h00, "lu_rd0"};
        tab[2]  = '{5'd5, 5'd3, 1'b0, 1'b1, OP_LD, 7'd0, 3'd2, 1'b1, 5'd5, 1'b0, 8'h00, "lu_rs1_unused"};
        tab[3]  = '{5'd5, 5'd0, 1'b1, 1'b0, OP_LD, 7'd0, 3'd2, 1'b1, 5'd5, 1'b1, 8'h28, "br_over_lu"};
        tab[4]  = '{5'd2, 5'd3, 1'b1, 1'b1, OP_BR, 7'd0, 3'd0, 1'b0, 5'd0, 1'b1, 8'h28, "br_only"};
        tab[5]  = '{5'd0, 5'd0, 1'b0, 1'b0, OP_R,  7'd1, 3'd0, 1'b0, 5'd9, 1'b0, 8'h01, "mul_lat0"};
        tab[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, OP_R,  7'd1, 3'd3, 1'b0, 5'd9, 1'b0, 8'h01, "mulhu_lat0"};
        tab[7]  = '{5'd7, 5'd1, 1'b1, 1'b0, OP_LD, 7'd0, 3'd2, 1'b1, 5'd7, 1'b0, 8'hC8, "lu_rs1"};
        tab[8]  = '{5'd5, 5'd5, 1'b1, 1'b1, OP_R,  7'd0, 3'd0, 1'b0, 5'd5, 1'b0, 8'h00, "alu_no_load"};
        tab[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, OP_R,  7'd0, 3'd4, 1'b0, 5'd1, 1'b0, 8'h00, "xor_not_m"};
        tab[10] = '{5'd0, 5'd0, 1'b0, 1'b0, OP_I,  7'd1, 3'd4, 1'b0, 5'd1, 1'b0, 8'h00, "imm_not_m"};

        set_idle();
        #2;
        chk("reset_out", 32'(outv), 32'h0);
        chk("reset_perf_stall", perf_stall_cycles, 32'h0);
        chk("reset_perf_flush", perf_flushes, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tab[i]);
            cycle(tab[i].name, 1'b1, tab[i].exp);
        end

        // DIV with latency 4: holds cycles 0-4, busy 1-4, done at cycle 5
        set_div();
        for (int k = 0; k < 6; k++)
            cycle($sformatf("div_c%0d", k), 1'b1, k == 0 ? 8'hD4 : k < 5 ? 8'hD6 : 8'h01);
        set_idle();
        cycle("div_after", 1'b1, 8'h00);

        // back-to-back single-cycle MULs never stall
        drive(tab[5]);
        for (int k = 0; k < 3; k++) cycle($sformatf("mul_b2b%0d", k), 1'b1, 8'h01);
        set_idle();
        cycle("mul_after", 1'b1, 8'h00);

        for (int i = 0; i < 400; i++) begin
            gen();
            cycle("rand", 1'b0, 8'h00);
        end
        set_idle();
        while (age >= 0) cycle("drain", 1'b0, 8'h00);
        chk("perf_stall", perf_stall_cycles, PERF ? exp_s : 32'h0);
        chk("perf_flush", perf_flushes, PERF ? exp_f : 32'h0);

        // asynchronous reset in the middle of a DIV wait abandons it without a done
        set_div();
        cycle("rw_c0", 1'b1, 8'hD4);
        cycle("rw_c1", 1'b1, 8'hD6);
        set_idle();
        #2 rst = 1'b1;
        age = -1; exp_s = 0; exp_f = 0;
        #1;
        chk("rst_async_out", 32'(outv), 32'h0);
        chk("rst_perf_stall", perf_stall_cycles, 32'h0);
        chk("rst_perf_flush", perf_flushes, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) cycle($sformatf("post_rst%0d", k), 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
